// File: rtl/store_size_unit.sv
// -----------------------------------------------------------------------------
// store_size_unit
//
// Store path from register B to a word-only data memory. It handles SW, SH and
// SB stores. Word stores are written directly. Halfword and byte stores read
// the addressed word, merge the new lane into it, and write the word back.
// Completion is reported with a one-cycle done pulse.
//
// Optional feature (compile-time macro STORE_ALIGN_CHECK_EN):
//   When defined, SW with addr[1:0]!=0 or SH with addr[0]!=0 skips memory and
//   finishes with done and misaligned_exc asserted together. When undefined,
//   misaligned_exc stays 0 and the faulting low address bits are ignored.
//
// Parameters:
//   MEM_LATENCY    cycles from read address to valid mem_rdata (1..15)
//
// Ports:
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   start          one-cycle request, sampled only in IDLE
//   store_size     0=SW, 1=SH, 2=SB, 3=reserved (completes with no access)
//   addr           byte address (ALUOut)
//   b_data         store data (register B)
//   mem_rdata      memory read word
//   mem_addr       word-aligned memory address (registered)
//   mem_wdata      merged write word (registered, held between writes)
//   mem_wr         one-cycle memory write strobe (registered)
//   busy           high from the cycle after start until done
//   done           one-cycle completion pulse
//   misaligned_exc one-cycle alignment fault pulse, coincident with done
// -----------------------------------------------------------------------------
module store_size_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  store_size,
  input  logic [31:0] addr,
  input  logic [31:0] b_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        misaligned_exc
);

  localparam logic [1:0] SIZE_W   = 2'd0;
  localparam logic [1:0] SIZE_H   = 2'd1;
  localparam logic [1:0] SIZE_B   = 2'd2;
  localparam logic [1:0] SIZE_RSV = 2'd3;
  localparam logic [3:0] LAT_INIT = 4'(MEM_LATENCY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [1:0]  size_r, size_s;
  logic [1:0]  lane_r, lane_s;
  logic [31:0] bdata_r, bdata_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [31:0] mem_addr_s;
  logic [31:0] mem_wdata_s;
  logic        mem_wr_s;
  logic        busy_s;
  logic        done_s;
  logic        exc_s;
  logic        misalign_s;

  // Replace the selected lane of a memory word with store data (little-endian).
  // The halfword lane is chosen by lane[1] alone, so an odd SH address falls
  // back to the halfword that contains it.
  function automatic logic [31:0] merge_store(
    input logic [1:0]  size,
    input logic [1:0]  lane,
    input logic [31:0] word,
    input logic [31:0] data
  );
    logic [31:0] merged;
    merged = word;
    case (size)
      SIZE_H: begin
        if (lane[1]) begin
          merged[31:16] = data[15:0];
        end else begin
          merged[15:0] = data[15:0];
        end
      end
      SIZE_B: begin
        case (lane)
          2'd0:    merged[7:0]   = data[7:0];
          2'd1:    merged[15:8]  = data[7:0];
          2'd2:    merged[23:16] = data[7:0];
          default: merged[31:24] = data[7:0];
        endcase
      end
      default: merged = data;
    endcase
    return merged;
  endfunction

  // Alignment fault detection on the live request inputs (IDLE only uses it).
  always_comb begin
`ifdef STORE_ALIGN_CHECK_EN
    case (store_size)
      SIZE_W:  misalign_s = (addr[1:0] != 2'b00);
      SIZE_H:  misalign_s = addr[0];
      default: misalign_s = 1'b0;
    endcase
`else
    misalign_s = 1'b0;
`endif
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead so
  // they can be registered and still line up with the state they belong to.
  always_comb begin
    state_s     = state_r;
    size_s      = size_r;
    lane_s      = lane_r;
    bdata_s     = bdata_r;
    cnt_s       = cnt_r;
    mem_addr_s  = mem_addr;
    mem_wdata_s = mem_wdata;
    mem_wr_s    = 1'b0;
    busy_s      = busy;
    done_s      = 1'b0;
    exc_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          size_s  = store_size;
          lane_s  = addr[1:0];
          bdata_s = b_data;
          if (misalign_s || (store_size == SIZE_RSV)) begin
            // No memory access: finish straight away.
            state_s = DONE;
            done_s  = 1'b1;
            exc_s   = misalign_s;
            busy_s  = 1'b0;
          end else if (store_size == SIZE_W) begin
            state_s     = WRITE;
            mem_addr_s  = {addr[31:2], 2'b00};
            mem_wdata_s = b_data;
            mem_wr_s    = 1'b1;
            busy_s      = 1'b1;
          end else begin
            state_s    = READ;
            mem_addr_s = {addr[31:2], 2'b00};
            cnt_s      = LAT_INIT;
            busy_s     = 1'b1;
          end
        end else begin
          busy_s = 1'b0;
        end
      end
      READ: begin
        // cnt_r==1 marks the cycle in which mem_rdata is valid.
        if (cnt_r == 4'd1) begin
          state_s     = WRITE;
          mem_wdata_s = merge_store(size_r, lane_r, mem_rdata, bdata_r);
          mem_wr_s    = 1'b1;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      WRITE: begin
        state_s = DONE;
        done_s  = 1'b1;
        busy_s  = 1'b0;
      end
      DONE: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, captured operands and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      size_r         <= 2'd0;
      lane_r         <= 2'd0;
      bdata_r        <= 32'd0;
      cnt_r          <= 4'd0;
      mem_addr       <= 32'd0;
      mem_wdata      <= 32'd0;
      mem_wr         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      misaligned_exc <= 1'b0;
    end else begin
      state_r        <= state_s;
      size_r         <= size_s;
      lane_r         <= lane_s;
      bdata_r        <= bdata_s;
      cnt_r          <= cnt_s;
      mem_addr       <= mem_addr_s;
      mem_wdata      <= mem_wdata_s;
      mem_wr         <= mem_wr_s;
      busy           <= busy_s;
      done           <= done_s;
      misaligned_exc <= exc_s;
    end
  end

endmodule

// File: tb/tb_store_size_unit.sv
// -----------------------------------------------------------------------------
// tb_store_size_unit
//
// Self-checking bench for store_size_unit. The expected write word, write and
// done cycles and the exception flag come from an arithmetic reference model
// of the store rules. The memory model returns the stored word only in the
// cycle where read data is due and returns random data otherwise. Honours
// STORE_ALIGN_CHECK_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_store_size_unit;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  store_size;
  logic [31:0] addr;
  logic [31:0] b_data;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        busy;
  logic        done;
  logic        misaligned_exc;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] mem_word = 32'h0;
  int          rd_cnt = 0;

  always #5 clk = ~clk;

  store_size_unit #(.MEM_LATENCY(LAT)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .store_size     (store_size),
    .addr           (addr),
    .b_data         (b_data),
    .mem_rdata      (mem_rdata),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wr         (mem_wr),
    .busy           (busy),
    .done           (done),
    .misaligned_exc (misaligned_exc)
  );

  // Memory read model: data is valid only LAT cycles into a read.
  always @(negedge clk) begin
    if (busy && !mem_wr) rd_cnt = rd_cnt + 1;
    else rd_cnt = 0;
    mem_rdata = (rd_cnt == LAT) ? mem_word : $urandom;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_write(input int size, input logic [31:0] a,
                                              input logic [31:0] d, input logic [31:0] old);
    int sh;
    logic [31:0] m;
    if (size == 0) return d;
    if (size == 1) begin
      sh = ((a / 2) % 2) * 16;
      m  = 32'hFFFF << sh;
      return (old & ~m) | ((d & 32'hFFFF) << sh);
    end
    sh = (a % 4) * 8;
    m  = 32'hFF << sh;
    return (old & ~m) | ((d & 32'hFF) << sh);
  endfunction

  function automatic bit model_misaligned(input int size, input logic [31:0] a);
`ifdef STORE_ALIGN_CHECK_EN
    return ((size == 0) && (a % 4 != 0)) || ((size == 1) && (a % 2 != 0));
`else
    return 1'b0;
`endif
  endfunction

  // One store, optionally re-asserting start with junk operands while busy.
  task automatic run_op(input logic [1:0] size, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] word, input bit poke);
    bit          direct;
    bit          exc_e;
    bit          busy_ok = 1'b1;
    int          wr_c;
    int          done_c;
    int          n_wr = 0;
    int          n_done = 0;
    int          got_wr_c = -1;
    int          got_done_c = -1;
    logic [31:0] got_waddr = 32'h0;
    logic [31:0] got_wdata = 32'h0;
    logic        got_exc = 1'b0;
    logic [31:0] wexp;
    exc_e  = model_misaligned(int'(size), a);
    direct = exc_e || (size == 2'd3);
    if (direct) begin
      wr_c = -1; done_c = 1;
    end else if (size == 2'd0) begin
      wr_c = 1; done_c = 2;
    end else begin
      wr_c = LAT + 1; done_c = LAT + 2;
    end
    wexp     = model_write(int'(size), a, d, word);
    mem_word = word;
    @(negedge clk);
    start = 1'b1; store_size = size; addr = a; b_data = d;
    for (int c = 1; c <= LAT + 6; c++) begin
      @(negedge clk);
      if (mem_wr) begin
        n_wr++; got_wr_c = c; got_waddr = mem_addr; got_wdata = mem_wdata;
      end
      if (done) begin
        n_done++; got_done_c = c; got_exc = misaligned_exc;
      end
      if (busy !== (c < done_c)) busy_ok = 1'b0;
      start      = poke && (c <= done_c) && ($urandom_range(1, 0) == 1);
      store_size = 2'($urandom);
      addr       = $urandom;
      b_data     = $urandom;
    end
    start = 1'b0;
    check("write_count", 64'(n_wr), 64'(direct ? 0 : 1));
    if (!direct) begin
      check("write_cycle", 64'(got_wr_c), 64'(wr_c));
      check("write_addr", 64'(got_waddr), 64'(a & 32'hFFFF_FFFC));
      check("write_data", 64'(got_wdata), 64'(wexp));
      check("wdata_hold", 64'(mem_wdata), 64'(wexp));
    end
    check("done_count", 64'(n_done), 64'd1);
    check("done_cycle", 64'(got_done_c), 64'(done_c));
    check("misaligned", 64'(got_exc), 64'(exc_e));
    check("busy_window", 64'(busy_ok), 64'd1);
  endtask

  initial begin
    int quiet;
    reset_n = 1'b0; start = 1'b0; store_size = 2'd0; addr = 32'h0; b_data = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_data", {mem_addr, mem_wdata}, 64'h0);
    check("reset_ctl", 64'({mem_wr, busy, done, misaligned_exc}), 64'h0);
    reset_n = 1'b1;

    run_op(2'd0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0);
    run_op(2'd2, 32'h102, 32'h000000AA, 32'h11223344, 1'b0);
    run_op(2'd1, 32'h106, 32'h1234BEEF, 32'hCAFEF00D, 1'b0);
    run_op(2'd1, 32'h101, 32'h0000ABCD, 32'h55667788, 1'b0);
    run_op(2'd0, 32'h203, 32'h0BADF00D, 32'h0, 1'b0);
    run_op(2'd3, 32'h300, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    run_op(2'd2, 32'h303, 32'h00000077, 32'hFFFFFFFF, 1'b1);

    // Reset in the middle of a read: outputs clear at once, no write follows.
    mem_word = 32'h0;
    @(negedge clk);
    start = 1'b1; store_size = 2'd2; addr = 32'h500; b_data = 32'h11;
    @(negedge clk);
    start = 1'b0;
    check("read_busy", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_data", {mem_addr, mem_wdata}, 64'h0);
    check("midreset_ctl", 64'({mem_wr, busy, done, misaligned_exc}), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    quiet = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (mem_wr || done || busy) quiet++;
    end
    check("after_reset_idle", 64'(quiet), 64'd0);
    run_op(2'd0, 32'h40C, 32'h13579BDF, 32'h0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), $urandom, $urandom, $urandom, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/store_size_unit.md
Name: store_size_unit

Overview:
- Store-path counterpart of the writeback select logic: moves data from register B out to memory for SW, SH and SB.
- Sits between the control unit, the B register / ALUOut address and the byte-addressed data memory.
- The memory port only writes whole words, so SH and SB run a read-modify-write sequence. Word stores write directly.
- Reports completion to the control FSM with a done pulse.

Parameters:
- MEM_LATENCY, 1: cycles from issuing a read address until mem_rdata is valid; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- store_size  input  2  0=SW, 1=SH, 2=SB, 3=reserved
- addr  input  32  byte address (from ALUOut)
- b_data  input  32  store data (register B)
- mem_rdata  input  32  memory read word
- mem_addr  output  32  word-aligned memory address, registered
- mem_wdata  output  32  merged write word, registered
- mem_wr  output  1  memory write strobe, one cycle
- busy  output  1  high from the cycle after start until done
- done  output  1  one-cycle completion pulse
- misaligned_exc  output  1  one-cycle pulse together with done on an alignment fault

Behaviour:
- Reset: reset_n low forces, asynchronously, state=IDLE and all outputs to 0 (mem_addr, mem_wdata, mem_wr, busy, done, misaligned_exc).
- Reset during READ or WRITE abandons the operation; no partial write completes after reset_n rises.
- Input capture: start in IDLE latches store_size, addr and b_data.
  - Later changes to these inputs do not affect the operation in flight.
  - start while busy or in DONE is ignored; it is neither queued nor reported.
- Address and lanes:
  - mem_addr = {addr[31:2], 2'b00}; lane = addr[1:0]; little-endian.
  - Byte k occupies bits [8k+7:8k]; halfword at lane 0 occupies [15:0], at lane 2 occupies [31:16].
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - on start with SW → WRITE;
  - SH/SB → READ, wait counter loaded with MEM_LATENCY;
  - reserved size → DONE, no memory access, no exception.
- READ:
  - mem_addr is driven, mem_wr=0, counter decrements each cycle.
  - When the counter reaches 1, capture mem_rdata in that cycle and go to WRITE.
- WRITE: one cycle with mem_wr=1 and mem_wdata set as follows.
  - SW: b_data.
  - SH: captured word with the selected halfword replaced by b_data[15:0].
  - SB: captured word with the selected byte replaced by b_data[7:0].
  - Then → DONE.
- DONE: done=1 for one cycle, busy=0 in that cycle, → IDLE.
- Latency from start (cycle 0):
  - SW: write in cycle 1, done in cycle 2.
  - SH/SB: write in cycle MEM_LATENCY+1, done in cycle MEM_LATENCY+2.
- mem_wr is never high outside WRITE. mem_wdata holds its last value when not writing.

Optional Feature:
- Macro: STORE_ALIGN_CHECK_EN.
- Defined: SW with addr[1:0]≠0, or SH with addr[0]≠0, goes IDLE → DONE. Memory is not accessed, and misaligned_exc=1 together with done.
- Undefined: misaligned_exc is tied to 0, no alignment check is made, and the faulting low address bits are ignored.
  - SW treats the address as aligned.
  - SH uses lane addr[1] only.

Test Plan:
- SW, addr=0x100, b_data=0xDEADBEEF → cycle 1: mem_wr=1, mem_addr=0x100, mem_wdata=0xDEADBEEF; cycle 2: done=1.
- SB, addr=0x102, b_data=0x000000AA, memory word 0x11223344, MEM_LATENCY=1 → cycle 1 read of 0x100; cycle 2 write of 0x11AA3344; cycle 3 done.
- SH, addr=0x106, b_data=0x1234BEEF, memory word 0xCAFEF00D, MEM_LATENCY=3 → write of 0xBEEFF00D to 0x104 in cycle 4; done in cycle 5.
- SH, addr=0x101, with STORE_ALIGN_CHECK_EN → no mem_wr; cycle 1: done=1 and misaligned_exc=1. Without the macro → write with halfword lane 0 and misaligned_exc=0.
- SB started, then reset_n pulsed low during READ → all outputs 0 immediately, no write occurs; a following SW completes normally.
- start re-asserted with different operands during READ → ignored; the original write value is unchanged and exactly one done pulse is produced.
